// File: rtl/fpga_status_led_ctrl.sv
// Board status LED controller: per-LED OFF/ON/heartbeat/exit modes driven by a
// free-running prescaler and a one-shot exit latch that blinks a count code on failure.
module fpga_status_led_ctrl #(
    parameter int NUM_LEDS   = 4,
    parameter int PRESCALE_W = 27,
    parameter int TICK_W     = 24,
    parameter int CODE_W     = 4,
    parameter int GAP_TICKS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2*NUM_LEDS-1:0] mode_i,
    input  logic                  exit_valid_i,
    input  logic [31:0]           exit_value_i,
    output logic [NUM_LEDS-1:0]   led_o,
    output logic                  tick_o,
    output logic                  exit_done_o,
    output logic                  exit_pass_o,
    output logic [31:0]           exit_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_F_ON,
        S_F_OFF,
        S_F_GAP
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_ON        = 2'd1,
        MODE_HEARTBEAT = 2'd2,
        MODE_EXIT      = 2'd3
    } led_mode_t;

    localparam int CNT_W = CODE_W + 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [GAP_W-1:0]      gap_t;
    typedef logic [PRESCALE_W-1:0] presc_t;

    localparam gap_t   GAP_LOAD     = gap_t'(GAP_TICKS - 1);
    localparam presc_t PRESCALE_ONE = presc_t'(1);

    presc_t                prescale;
    state_t                state;
    cnt_t                  blink_rem;
    gap_t                  gap_rem;
    logic                  exit_level;
    logic [NUM_LEDS-1:0]   led_next;

    // Pulses remaining after the current one; a zero code field with a nonzero
    // value means the full 2^CODE_W pulses.
    function automatic cnt_t blink_load(input logic [CODE_W-1:0] code);
        cnt_t n;
        n = (code == '0) ? (cnt_t'(1) << CODE_W) : {1'b0, code};
        return n - cnt_t'(1);
    endfunction

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRESCALE_ONE;
        end
    end

    assign tick_o = &prescale[TICK_W-1:0];

    // NOTE: every register, including the counters, is cleared by reset so a
    // mid-blink reset leaves no stale count behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            blink_rem   <= '0;
            gap_rem     <= '0;
            exit_done_o <= 1'b0;
            exit_pass_o <= 1'b0;
            exit_code_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The latch is immediate; it does not wait for a tick.
                    if (exit_valid_i) begin
                        exit_code_o <= exit_value_i;
                        exit_done_o <= 1'b1;
                        exit_pass_o <= (exit_value_i == 32'd0);
                        if (exit_value_i == 32'd0) begin
                            state <= S_PASS;
                        end else begin
                            state     <= S_F_ON;
                            blink_rem <= blink_load(exit_value_i[CODE_W-1:0]);
                        end
                    end
                end
                S_PASS: begin
                    state <= S_PASS;
                end
                S_F_ON: begin
                    if (tick_o) begin
                        state <= S_F_OFF;
                    end
                end
                S_F_OFF: begin
                    if (tick_o) begin
                        if (blink_rem != '0) begin
                            state     <= S_F_ON;
                            blink_rem <= blink_rem - cnt_t'(1);
                        end else begin
                            state   <= S_F_GAP;
                            gap_rem <= GAP_LOAD;
                        end
                    end
                end
                S_F_GAP: begin
                    if (tick_o) begin
                        if (gap_rem != '0) begin
                            gap_rem <= gap_rem - gap_t'(1);
                        end else begin
                            state     <= S_F_ON;
                            blink_rem <= blink_load(exit_code_o[CODE_W-1:0]);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign exit_level = (state == S_PASS) || (state == S_F_ON);

    // NOTE: led_next gets a default before the loop so no path through the
    // case leaves it unassigned, which would infer a latch.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (led_mode_t'(mode_i[2*i +: 2]))
                MODE_OFF:       led_next[i] = 1'b0;
                MODE_ON:        led_next[i] = 1'b1;
                MODE_HEARTBEAT: led_next[i] = prescale[PRESCALE_W-1];
                MODE_EXIT:      led_next[i] = exit_level;
                default:        led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= led_next;
        end
    end

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Self-checking bench for fpga_status_led_ctrl: expected LED/exit outputs are
// derived from cycle arithmetic, queued at drive time and compared after the edge.
module tb_fpga_status_led_ctrl;

    localparam int NUM_LEDS    = 4;
    localparam int PRESCALE_W  = 4;
    localparam int TICK_W      = 2;
    localparam int CODE_W      = 4;
    localparam int GAP_TICKS   = 4;
    localparam int TICK_PERIOD = 1 << TICK_W;
    localparam int P_PERIOD    = 1 << PRESCALE_W;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [2*NUM_LEDS-1:0] mode_i;
    logic                  exit_valid_i;
    logic [31:0]           exit_value_i;
    logic [NUM_LEDS-1:0]   led_o;
    logic                  tick_o;
    logic                  exit_done_o;
    logic                  exit_pass_o;
    logic [31:0]           exit_code_o;

    always #5 clk_i = ~clk_i;

    fpga_status_led_ctrl #(
        .NUM_LEDS   (NUM_LEDS),
        .PRESCALE_W (PRESCALE_W),
        .TICK_W     (TICK_W),
        .CODE_W     (CODE_W),
        .GAP_TICKS  (GAP_TICKS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mode_i       (mode_i),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .led_o        (led_o),
        .tick_o       (tick_o),
        .exit_done_o  (exit_done_o),
        .exit_pass_o  (exit_pass_o),
        .exit_code_o  (exit_code_o)
    );

    typedef struct {
        logic [NUM_LEDS-1:0] led;
        logic                done;
        logic                pass;
        logic [31:0]         code;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          known = 1'b0;
    bit          latched = 1'b0;
    int          latch_cyc = 0;
    logic [31:0] latch_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    function automatic int blink_count(input logic [31:0] v);
        int n;
        n = int'(v[CODE_W-1:0]);
        if (n == 0) n = 1 << CODE_W;
        return n;
    endfunction

    // Exit-mode level during cycle c. The partial first pulse is treated as the
    // tail of a full pulse starting at 'origin', after which the code is periodic.
    function automatic bit exit_level(input int c);
        int first_tick;
        int origin;
        int n;
        int j;
        if (!latched || c <= latch_cyc) return 1'b0;
        if (latch_val == 32'd0) return 1'b1;
        first_tick = latch_cyc + 1 + ((TICK_PERIOD - 1) - ((latch_cyc + 1) % TICK_PERIOD));
        if (c <= first_tick) return 1'b1;
        origin = first_tick - (TICK_PERIOD - 1);
        n = blink_count(latch_val);
        j = ((c - origin) / TICK_PERIOD) % (2 * n + GAP_TICKS);
        return (j < 2 * n) && (j % 2 == 0);
    endfunction

    function automatic logic [NUM_LEDS-1:0] led_expect(input logic [2*NUM_LEDS-1:0] mode, input int c);
        logic [NUM_LEDS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode[2*i +: 2])
                2'd0: r[i] = 1'b0;
                2'd1: r[i] = 1'b1;
                2'd2: r[i] = ((c % P_PERIOD) >= (P_PERIOD / 2));
                default: r[i] = exit_level(c);
            endcase
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, queue what the registered outputs must show
    // after the edge, then compare once the edge has happened.
    task automatic drive_cycle(input logic rst, input logic [2*NUM_LEDS-1:0] mode,
                               input logic ev, input logic [31:0] val);
        exp_t e;
        exp_t got;
        rst_i        = rst;
        mode_i       = mode;
        exit_valid_i = ev;
        exit_value_i = val;
        if (known) check("tick", 32'(tick_o), 32'((cyc % TICK_PERIOD) == TICK_PERIOD - 1));
        if (rst) begin
            latched = 1'b0;
            e = '{led: '0, done: 1'b0, pass: 1'b0, code: '0};
        end else begin
            if (ev && !latched) begin
                latched   = 1'b1;
                latch_cyc = cyc;
                latch_val = val;
            end
            e.led  = led_expect(mode, cyc);
            e.done = latched;
            e.pass = latched && (latch_val == 32'd0);
            e.code = latched ? latch_val : 32'd0;
        end
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (rst) begin
            cyc   = 0;
            known = 1'b1;
        end else begin
            cyc++;
        end
        got = sb.pop_front();
        check("led",       32'(led_o),       32'(got.led));
        check("exit_done", 32'(exit_done_o), 32'(got.done));
        check("exit_pass", 32'(exit_pass_o), 32'(got.pass));
        check("exit_code", exit_code_o,      got.code);
    endtask

    task automatic run(input int n, input logic rst, input logic [2*NUM_LEDS-1:0] mode,
                       input logic ev, input logic [31:0] val);
        for (int k = 0; k < n; k++) drive_cycle(rst, mode, ev, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        mode_i       = '0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;

        // Reset and static modes
        run(3,  1'b1, 8'h55, 1'b0, 32'd0);
        run(12, 1'b0, 8'h55, 1'b0, 32'd0);
        run(3,  1'b0, 8'h00, 1'b0, 32'd0);

        // Heartbeat on every LED
        run(2,  1'b1, 8'hAA, 1'b0, 32'd0);
        run(40, 1'b0, 8'hAA, 1'b0, 32'd0);

        // Pass, with a later nonzero exit value that must be ignored
        run(2,  1'b1, 8'hFF, 1'b0, 32'd0);
        run(5,  1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'd0);
        run(3,  1'b0, 8'hFF, 1'b0, 32'd0);
        run(30, 1'b0, 8'hFF, 1'b1, 32'hDEAD_0007);

        // Fail value 3, mixed modes (LED3 exit, LED2 heartbeat, LED1 on, LED0 off)
        run(2,   1'b1, 8'hE4, 1'b0, 32'd0);
        run(5,   1'b0, 8'hE4, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hE4, 1'b1, 32'd3);
        run(100, 1'b0, 8'hE4, 1'b0, 32'd0);

        // Latch in the same cycle as a tick: full first pulse
        run(2,  1'b1, 8'hFF, 1'b0, 32'd0);
        run(3,  1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'd2);
        run(60, 1'b0, 8'hFF, 1'b0, 32'd0);

        // Latch the cycle before a tick: one-cycle first pulse
        run(2,  1'b1, 8'hFF, 1'b0, 32'd0);
        run(6,  1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'd1);
        run(60, 1'b0, 8'hFF, 1'b0, 32'd0);

        // Code field wraps to 16 pulses; a later pass value is ignored
        run(2,   1'b1, 8'hFF, 1'b0, 32'd0);
        run(2,   1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'h10);
        run(150, 1'b0, 8'hFF, 1'b0, 32'd0);
        run(2,   1'b0, 8'hFF, 1'b1, 32'd0);
        run(160, 1'b0, 8'hFF, 1'b0, 32'd0);

        // Reset during the second pulse of value 5, then a fresh pass
        run(2,  1'b1, 8'hFF, 1'b0, 32'd0);
        run(4,  1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'd5);
        run(8,  1'b0, 8'hFF, 1'b0, 32'd0);
        run(2,  1'b1, 8'hFF, 1'b0, 32'd0);
        run(4,  1'b0, 8'hFF, 1'b0, 32'd0);
        drive_cycle(1'b0, 8'hFF, 1'b1, 32'd0);
        run(10, 1'b0, 8'hFF, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
